// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM state encoding, parity modes and vote helper.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_HIGH = 3'd5
  } rx_state_t;

  // 2-of-3 majority used for mid-bit noise rejection
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_bit_sync.sv
// Two-flop synchroniser for a single asynchronous input, with selectable reset level.
module rx_bit_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: oversampled start/data/parity/stop recovery with
// mid-bit majority voting and a single-entry valid/ready output register.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned SAMPLE_RATE = 16,
  parameter int unsigned PARITY      = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_RATE);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_VA   = CNT_W'(SAMPLE_RATE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_VB   = CNT_W'(SAMPLE_RATE / 2);
  localparam logic [CNT_W-1:0] CNT_VOTE = CNT_W'(SAMPLE_RATE / 2 + 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(SAMPLE_RATE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  localparam logic [STATE_W-1:0] ST_IDLE      = RX_IDLE;
  localparam logic [STATE_W-1:0] ST_START     = RX_START;
  localparam logic [STATE_W-1:0] ST_DATA      = RX_DATA;
  localparam logic [STATE_W-1:0] ST_PARITY    = RX_PARITY;
  localparam logic [STATE_W-1:0] ST_STOP      = RX_STOP;
  localparam logic [STATE_W-1:0] ST_WAIT_HIGH = RX_WAIT_HIGH;

  logic                 rx_s;
  logic [STATE_W-1:0]   state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 vote_a, vote_a_nxt;
  logic                 vote_b, vote_b_nxt;
  logic                 perr_pend, perr_pend_nxt;
  logic [DATA_BITS-1:0] data_nxt;
  logic                 perr_nxt, ferr_nxt, valid_nxt, overrun_nxt, busy_nxt;
  logic                 vote_c, done_c, ferr_c;
  logic                 at_va, at_vb, at_vote, at_end;

  rx_bit_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_in),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      vote_a     <= 1'b1;
      vote_b     <= 1'b1;
      perr_pend  <= 1'b0;
      rx_data    <= '0;
      rx_perr    <= 1'b0;
      rx_ferr    <= 1'b0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bit_idx    <= bit_idx_nxt;
      shift      <= shift_nxt;
      vote_a     <= vote_a_nxt;
      vote_b     <= vote_b_nxt;
      perr_pend  <= perr_pend_nxt;
      rx_data    <= data_nxt;
      rx_perr    <= perr_nxt;
      rx_ferr    <= ferr_nxt;
      rx_valid   <= valid_nxt;
      rx_overrun <= overrun_nxt;
      rx_busy    <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    bit_idx_nxt   = bit_idx;
    shift_nxt     = shift;
    vote_a_nxt    = vote_a;
    vote_b_nxt    = vote_b;
    perr_pend_nxt = perr_pend;
    done_c        = 1'b0;
    ferr_c        = 1'b0;
    at_va         = (cnt == CNT_VA);
    at_vb         = (cnt == CNT_VB);
    at_vote       = (cnt == CNT_VOTE);
    at_end        = (cnt == CNT_END);
    vote_c        = majority3(vote_a, vote_b, rx_s);

    // Bit-period timing and vote capture run only while inside a frame
    if (rx_tick && state != ST_IDLE && state != ST_WAIT_HIGH) begin
      cnt_nxt = at_end ? '0 : cnt + CNT_W'(1);
      if (at_va) vote_a_nxt = rx_s;
      if (at_vb) vote_b_nxt = rx_s;
    end

    case (state)
      ST_IDLE: begin
        if (rx_tick && !rx_s) begin
          state_nxt     = ST_START;
          cnt_nxt       = '0;
          perr_pend_nxt = 1'b0;
        end
      end
      ST_START: begin
        if (rx_tick) begin
          if (at_vote && vote_c) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end else if (at_end) begin
            state_nxt   = ST_DATA;
            bit_idx_nxt = '0;
          end
        end
      end
      ST_DATA: begin
        if (rx_tick) begin
          if (at_vote) shift_nxt = {vote_c, shift[DATA_BITS-1:1]};
          if (at_end) begin
            if (bit_idx == IDX_LAST) state_nxt = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            else                     bit_idx_nxt = bit_idx + IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (rx_tick) begin
          if (at_vote) perr_pend_nxt = (((^shift) ^ vote_c) != (PARITY == PARITY_ODD));
          if (at_end)  state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        // Frame completes at the stop-bit vote; the rest of the stop bit is not waited for
        if (rx_tick && at_vote) begin
          done_c    = 1'b1;
          ferr_c    = !vote_c;
          state_nxt = vote_c ? ST_IDLE : ST_WAIT_HIGH;
          cnt_nxt   = '0;
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_tick && rx_s) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Single-entry output register: load on completion if free or being drained, else drop
  always_comb begin
    data_nxt    = rx_data;
    perr_nxt    = rx_perr;
    ferr_nxt    = rx_ferr;
    valid_nxt   = rx_valid;
    overrun_nxt = 1'b0;
    busy_nxt    = (state_nxt != ST_IDLE);
    if (done_c) begin
      if (!rx_valid || rx_ready) begin
        data_nxt  = shift;
        perr_nxt  = perr_pend;
        ferr_nxt  = ferr_c;
        valid_nxt = 1'b1;
      end else begin
        overrun_nxt = 1'b1;
      end
    end else if (rx_valid && rx_ready) begin
      valid_nxt = 1'b0;
    end
  end

endmodule
